// File: rtl/mem_arbiter.sv
// Shared memory port arbiter between instruction fetch and data load/store.
// Data wins ties, but a fetch that has lost STARVE_MAX data grants in a row is served next.
module mem_arbiter #(
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned TMO        = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [1:0]  d_size,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [1:0]  mem_size,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        bus_err
);

  localparam int unsigned    TmoW      = (TMO < 2) ? 1 : $clog2(TMO + 1);
  localparam logic [2:0]     StarveMax = 3'(STARVE_MAX);
  localparam logic [TmoW-1:0] TmoLimit = TmoW'(TMO);

  typedef enum logic [1:0] {StIdle, StServeI, StServeD} state_e;

  state_e r_state, w_state_next;

  logic            r_if_ack, r_d_ack, r_bus_err, r_we;
  logic [31:0]     r_addr, r_wdata, r_if_rdata, r_d_rdata;
  logic [1:0]      r_size;
  logic [2:0]      r_starve;
  logic [TmoW-1:0] r_tmo;

  logic w_arb_en, w_grant_i, w_grant_d, w_serving, w_tmo_hit, w_done;

  // No arbitration during an ack cycle: the acked requester is still showing its old request.
  assign w_arb_en  = (r_state == StIdle) && !r_if_ack && !r_d_ack;
  assign w_grant_d = w_arb_en && d_req && !(if_req && (r_starve == StarveMax));
  assign w_grant_i = w_arb_en && if_req && !w_grant_d;
  assign w_serving = (r_state != StIdle);
  assign w_tmo_hit = (r_tmo == TmoLimit);
  assign w_done    = w_serving && (mem_ready || w_tmo_hit);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= StIdle;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_grant_d)      w_state_next = StServeD;
        else if (w_grant_i) w_state_next = StServeI;
      end
      StServeI, StServeD: begin
        if (w_done) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_if_ack   <= 1'b0;
      r_d_ack    <= 1'b0;
      r_bus_err  <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_size     <= '0;
      r_if_rdata <= '0;
      r_d_rdata  <= '0;
      r_starve   <= '0;
      r_tmo      <= '0;
    end else begin
      r_if_ack <= w_done && (r_state == StServeI);
      r_d_ack  <= w_done && (r_state == StServeD);
      if (w_grant_i) begin
        r_addr  <= if_addr;
        r_we    <= 1'b0;
        r_wdata <= '0;
        r_size  <= 2'b10;
      end else if (w_grant_d) begin
        r_addr  <= d_addr;
        r_we    <= d_we;
        r_wdata <= d_wdata;
        r_size  <= d_size;
      end
      if (w_grant_i) r_starve <= '0;
      else if (w_grant_d && if_req && (r_starve < StarveMax)) r_starve <= r_starve + 3'd1;
      if (w_grant_i || w_grant_d) r_tmo <= '0;
      else if (w_serving && !mem_ready && !w_tmo_hit) r_tmo <= r_tmo + TmoW'(1);
      // An abort returns zero data; stores always return zero.
      if (w_done && (r_state == StServeI)) r_if_rdata <= mem_ready ? mem_rdata : '0;
      if (w_done && (r_state == StServeD)) r_d_rdata <= (mem_ready && !r_we) ? mem_rdata : '0;
      if (w_serving && !mem_ready && w_tmo_hit) r_bus_err <= 1'b1;
    end
  end

  always_comb begin
    mem_req   = w_serving;
    mem_we    = r_we;
    mem_addr  = r_addr;
    mem_wdata = r_wdata;
    mem_size  = r_size;
    if_ack    = r_if_ack;
    d_ack     = r_d_ack;
    if_rdata  = r_if_rdata;
    d_rdata   = r_d_rdata;
    bus_err   = r_bus_err;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed plus randomized bench for mem_arbiter against a transaction-level arbitration model.
module tb_mem_arbiter;

  localparam int unsigned StarveMax = 4;
  localparam int unsigned Tmo       = 255;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [1:0]  d_size = '0;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [1:0]  mem_size;
  logic [31:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;
  logic        bus_err;

  int n_tests = 0;
  int n_fail  = 0;
  int starve_m;

  mem_arbiter #(.STARVE_MAX(StarveMax), .TMO(Tmo)) dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_size(d_size),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_size(mem_size), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .bus_err(bus_err)
  );

  always #5 clock = ~clock;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_grant(input string tag, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (mem_req === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    chk({tag, " grant"}, 32'(ok), 32'd1);
  endtask

  // Waits for the grant, checks the presented fields, answers after lat cycles.
  task automatic serve(input string tag, input bit is_i, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [1:0] size, input int lat,
                       input logic [31:0] rdata);
    bit ok;
    wait_grant(tag, ok);
    if (!ok) return;
    chk({tag, " addr"}, mem_addr, addr);
    chk({tag, " we"}, 32'(mem_we), 32'(we));
    chk({tag, " wdata"}, mem_wdata, wdata);
    chk({tag, " size"}, 32'(mem_size), 32'(size));
    repeat (lat) tick();
    chk({tag, " addr hold"}, mem_addr, addr);
    mem_ready = 1'b1;
    mem_rdata = rdata;
    tick();
    mem_ready = 1'b0;
    chk({tag, " if_ack"}, 32'(if_ack), 32'(is_i));
    chk({tag, " d_ack"}, 32'(d_ack), 32'(!is_i));
    if (is_i) chk({tag, " if_rdata"}, if_rdata, rdata);
    else      chk({tag, " d_rdata"}, d_rdata, we ? 32'h0 : rdata);
    chk({tag, " mem_req low"}, 32'(mem_req), 32'd0);
  endtask

  initial begin
    bit ok;
    int cnt;
    logic [31:0] exp_ird;

    // Reset state
    tick();
    tick();
    chk("rst mem_req", 32'(mem_req), 32'd0);
    chk("rst mem_addr", mem_addr, 32'd0);
    chk("rst acks", 32'({if_ack, d_ack}), 32'd0);
    chk("rst bus_err", 32'(bus_err), 32'd0);
    reset = 1'b0;

    // mem_ready while idle does nothing
    mem_ready = 1'b1;
    tick();
    tick();
    chk("idle ready acks", 32'({if_ack, d_ack}), 32'd0);
    chk("idle ready mem_req", 32'(mem_req), 32'd0);
    mem_ready = 1'b0;

    // Basic fetch, minimum latency
    if_req = 1'b1;
    if_addr = 32'h100;
    tick();
    chk("fetch min latency", 32'(mem_req), 32'd1);
    serve("fetch", 1'b1, 1'b0, 32'h100, 32'h0, 2'b10, 0, 32'h00500093);
    if_req = 1'b0;
    tick();
    chk("fetch ack pulse", 32'(if_ack), 32'd0);
    chk("fetch rdata held", if_rdata, 32'h00500093);

    // Simultaneous requests: store goes first
    if_req = 1'b1;
    if_addr = 32'h104;
    d_req = 1'b1;
    d_we = 1'b1;
    d_addr = 32'h2000;
    d_wdata = 32'hDEADBEEF;
    d_size = 2'b10;
    serve("tie store", 1'b0, 1'b1, 32'h2000, 32'hDEADBEEF, 2'b10, 1, 32'h12345678);
    d_req = 1'b0;
    serve("tie fetch", 1'b1, 1'b0, 32'h104, 32'h0, 2'b10, 0, 32'hCAFE0001);
    if_req = 1'b0;

    // Starvation bound, twice to show the counter restarts after a fetch grant
    if_req = 1'b1;
    if_addr = 32'h200;
    d_req = 1'b1;
    d_we = 1'b0;
    d_addr = 32'h3000;
    d_wdata = 32'h0;
    d_size = 2'b01;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < StarveMax; k++)
        serve("starve load", 1'b0, 1'b0, 32'h3000, 32'h0, 2'b01, k % 2, 32'h1000 + 32'(k));
      serve("starve fetch", 1'b1, 1'b0, 32'h200, 32'h0, 2'b10, 0, 32'hABCD0000 + 32'(r));
    end
    if_req = 1'b0;
    d_req = 1'b0;
    tick();
    tick();

    // Randomized rounds against the arbitration model
    starve_m = 0;
    for (int r = 0; r < 40; r++) begin
      bit pi, pd;
      logic dwe;
      logic [31:0] iaddr, daddr, dwd;
      logic [1:0] dsz;
      pi = 1'($urandom % 2);
      pd = 1'($urandom % 2);
      if (!pi && !pd) pi = 1'b1;
      iaddr = $urandom;
      daddr = $urandom;
      dwd = $urandom;
      dwe = 1'($urandom % 2);
      dsz = 2'($urandom % 4);
      if_req = pi;
      if_addr = iaddr;
      d_req = pd;
      d_we = dwe;
      d_addr = daddr;
      d_wdata = dwd;
      d_size = dsz;
      while (pi || pd) begin
        bit win_i;
        if (pi && pd) begin
          win_i = (starve_m == StarveMax);
          if (!win_i && starve_m < StarveMax) starve_m++;
        end else begin
          win_i = pi;
        end
        if (win_i) starve_m = 0;
        if (win_i) begin
          serve("rand fetch", 1'b1, 1'b0, iaddr, 32'h0, 2'b10, $urandom_range(0, 3), $urandom);
          pi = 1'b0;
          if_req = 1'b0;
        end else begin
          serve("rand data", 1'b0, dwe, daddr, dwd, dsz, $urandom_range(0, 3), $urandom);
          pd = 1'b0;
          d_req = 1'b0;
        end
      end
    end
    tick();
    tick();

    // Timeout abort
    if_req = 1'b1;
    if_addr = 32'h400;
    wait_grant("tmo", ok);
    cnt = 0;
    while (mem_req === 1'b1 && cnt < 300) begin
      cnt++;
      tick();
    end
    chk("tmo serve cycles", 32'((cnt == Tmo) || (cnt == Tmo + 1)), 32'd1);
    chk("tmo if_ack", 32'(if_ack), 32'd1);
    exp_ird = 32'h0;
    chk("tmo if_rdata", if_rdata, exp_ird);
    chk("tmo bus_err", 32'(bus_err), 32'd1);
    if_req = 1'b0;
    d_req = 1'b1;
    d_we = 1'b0;
    d_addr = 32'h44;
    d_size = 2'b10;
    serve("post tmo load", 1'b0, 1'b0, 32'h44, d_wdata, 2'b10, 2, 32'h5555AAAA);
    d_req = 1'b0;
    tick();
    chk("bus_err sticky", 32'(bus_err), 32'd1);

    // Asynchronous reset in the middle of a data access
    d_req = 1'b1;
    d_we = 1'b0;
    d_addr = 32'h5000;
    d_size = 2'b00;
    wait_grant("rst mid", ok);
    tick();
    #2;
    reset = 1'b1;
    #1;
    chk("async rst mem_req", 32'(mem_req), 32'd0);
    chk("async rst mem_addr", mem_addr, 32'd0);
    chk("async rst bus_err", 32'(bus_err), 32'd0);
    chk("async rst d_rdata", d_rdata, 32'd0);
    mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst no d_ack", 32'(d_ack), 32'd0);
    end
    mem_ready = 1'b0;
    reset = 1'b0;
    serve("reissue load", 1'b0, 1'b0, 32'h5000, d_wdata, 2'b00, 1, 32'h600DF00D);
    d_req = 1'b0;
    tick();
    chk("reissue d_ack pulse", 32'(d_ack), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
